fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the single-cycle-read instruction memory (`instr_memory`). It owns the program counter and presents a word address to the memory every cycle. It tracks the one-cycle read latency and delivers each returned instruction with its PC to the decode stage over a valid/ready handshake. It also handles stalls from decode and PC redirects from branch/jump resolution.

## Interface
- `ADDR_WIDTH`, 32: width of PC and of the memory address.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: byte PC loaded on reset. Bits [1:0] are ignored.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: fetch enable.
- `redirect_valid` in 1: load a new PC.
- `redirect_pc` in ADDR_WIDTH: byte target. Bits [1:0] are forced to 0.
- `imem_addr` out ADDR_WIDTH: word address to memory `Read_address`, equal to PC >> 2.
- `imem_rdata` in DATA_WIDTH: memory `Instruction`, valid one cycle after the address is sampled.
- `out_valid` out 1: an instruction is offered to decode.
- `out_ready` in 1: decode accepts.
- `out_instr` out DATA_WIDTH: the instruction. Driven to 0 when `out_valid`=0.
- `out_pc` out ADDR_WIDTH: byte PC of `out_instr`.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH when `run`=1.
  - FETCH → DRAIN when `run`=0 and an unaccepted instruction is pending or in flight.
  - FETCH → IDLE when `run`=0 and nothing is pending.
  - DRAIN → IDLE once every pending instruction has been accepted (or killed by a redirect).
- Registers:
  - `req_pc`: next PC to issue.
  - `rsp_pc`/`rsp_valid`: the address whose data appears on `imem_rdata` this cycle.
- Issue occurs at an edge where the state is IDLE→FETCH or FETCH, and the output slot is free or being accepted (`!out_valid || out_ready`). On issue:
  - `rsp_pc` <= `req_pc`, `rsp_valid` <= 1.
  - `req_pc` <= `req_pc` + 4, wrapping modulo 2^ADDR_WIDTH.
- Stall (`out_valid && !out_ready`): `req_pc`, `rsp_pc` and `rsp_valid` hold. `out_instr` and `out_pc` must stay stable until accepted.
- Redirect has priority over issue and stall in every state:
  - `req_pc` <= `redirect_pc & ~3`; all pending and in-flight instructions are killed (`out_valid` drops next cycle).
  - State is unchanged, except DRAIN → IDLE.
- Redirect coinciding with acceptance: the accepted instruction counts as delivered, and the redirect still applies.
- Reset values:
  - State IDLE, `req_pc`=`RESET_PC`, `rsp_valid`=0.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0, `imem_addr`=`RESET_PC`>>2.
- Reset asserted mid-stream discards everything with no handshake.
- No range check: addresses beyond the memory depth wrap per memory indexing. This is the program's responsibility.

## Timing
- Fetch latency: `run` sampled high at edge E gives `out_valid`=1 in the cycle after E, with `out_pc`=`RESET_PC`.
- Throughput: one instruction per cycle while `out_ready`=1.
- Redirect sampled at edge E:
  - Cycle after E: `imem_addr`=`redirect_pc`>>2, `out_valid`=0.
  - Issue happens at E+1; the target is valid in the cycle after E+1. This is a one-bubble penalty.
- `run` deassertion: no new issue at that edge; already-pending instructions are still delivered.

## Configuration
- `FETCH_SKID_EN` undefined:
  - `imem_addr` = stall ? `rsp_pc`>>2 : `req_pc`>>2, so the memory re-reads the held word.
  - This is a combinational path from `out_ready` to `imem_addr`.
  - `out_instr` = `imem_rdata` gated by `out_valid`.
- `FETCH_SKID_EN` defined:
  - `imem_addr` = `req_pc`>>2, registered only; no path from `out_ready`.
  - A one-entry skid register captures the in-flight response when a stall begins.
  - Issue is suppressed while the skid is full.
  - Output is taken from the skid when it is full, otherwise from `imem_rdata`.
  - Throughput and latency are unchanged; a redirect also clears the skid.

## Structure
- `fetch_pkg` contains:
  - `fetch_state_t` enum {IDLE, FETCH, DRAIN}.
  - `WORD_BYTES`=4.
  - Helper function `pc_to_word(pc)`.
- Sub-module `fetch_skid_buf` holds one (instr, pc) entry with load, unload and clear. It is instantiated only under `FETCH_SKID_EN`.

## Test plan
- Reset, then `run`=1, `out_ready`=1, memory holding 0x11,0x22,0x33 → `out_pc` 0,4,8 on consecutive cycles with `out_instr` 0x11,0x22,0x33, starting one cycle after `run`.
- `out_ready`=0 for 3 cycles while pc=4 is offered → `out_pc`=4 and `out_instr`=0x22 are held stable. On release, pc 8 follows the next cycle with no skipped or duplicated instruction.
- `redirect_valid`=1, `redirect_pc`=0x40 while pc=8 is offered and `out_ready`=0 → one cycle of `out_valid`=0, then `out_pc`=0x40. pc 8 is never accepted.
- `redirect_pc`=0x43 → `out_pc`=0x40 and `imem_addr`=0x10.
- `run` dropped during a stall with pc=0xC pending → pc 0xC is delivered after ready, then `out_valid`=0 and state is IDLE.
- `rst` asserted during a stall, and `req_pc` at 0xFFFFFFFC wrapping to 0 → all outputs take reset values next cycle. The wrap yields `out_pc` 0xFFFFFFFC then 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch controller.
//   fetch_state_t : controller FSM state (IDLE, FETCH, DRAIN)
//   WORD_BYTES    : bytes per instruction word (PC step)
//   pc_to_word()  : byte PC to word address conversion
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int WORD_BYTES = 4;

  // Works on a 64-bit container so any PC width up to 64 can use it;
  // callers cast the argument in and the result back to their own width.
  function automatic logic [63:0] pc_to_word(input logic [63:0] pc);
    return pc >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: groups the fetch controller's control inputs, the
// instruction-memory bus and the decode-side valid/ready channel.
//   run, redirect_valid, redirect_pc : fetch enable and PC redirect
//   imem_addr / imem_rdata           : word address out, instruction back
//                                      one cycle later
//   out_valid/out_ready/out_instr/out_pc : instruction offered to decode
// Handshake: a transfer happens at a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the offered
// out_instr/out_pc stay unchanged until accepted; out_valid only drops
// without a transfer on redirect or reset.
// modport master: the fetch controller. modport slave: its environment.
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  run;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    input  run, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output run, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an (instr, pc) pair.
//   clk, rst         : clock, synchronous active-high reset
//   load_i           : capture instr_i/pc_i and mark full
//   unload_i         : release the entry (mark empty)
//   clear_i          : drop the entry (highest priority after reset)
//   full_o, instr_o, pc_o : occupancy and stored pair
module fetch_skid_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  unload_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);
  logic                  full_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller for a single-cycle-read memory.
// Owns the PC, presents a word address every cycle, tracks the one-cycle
// read latency and hands each instruction with its PC to decode.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : fetch_ctrl_if.master (run/redirect, imem bus, decode channel)
//   state_dbg_o : current FSM state
// Build option: define FETCH_SKID_EN to register imem_addr (no out_ready ->
// imem_addr path) and hold a stalled response in a one-entry skid buffer.
// Without it, a stall re-presents the held word's address so the memory
// keeps returning the same instruction.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus,
  output fetch_state_t state_dbg_o
);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic redirect;
  logic out_valid;
  logic stall;
  logic slot_blocked;
  logic issue;

  assign redirect = bus.redirect_valid;
  assign stall    = out_valid && !bus.out_ready;

  // Redirect wins over everything; issue needs an output slot that is free
  // or being emptied this edge.
  assign issue = !redirect && bus.run &&
                 ((state_q == IDLE) || (state_q == FETCH)) &&
                 !stall && !slot_blocked;

`ifdef FETCH_SKID_EN
  logic                  skid_full;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic                  skid_load;
  logic                  skid_unload;

  // A stalled response is parked in the skid the first cycle it is refused;
  // after that the memory is free to follow req_pc.
  assign skid_load   = !redirect && rsp_valid_q && !skid_full && !bus.out_ready;
  assign skid_unload = skid_full && bus.out_ready;
  assign slot_blocked = skid_full;
  assign out_valid    = rsp_valid_q || skid_full;
  // Once parked, the response no longer lives on imem_rdata.
  assign rsp_valid_d  = issue;

  fetch_skid_buf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect),
    .instr_i  (bus.imem_rdata),
    .pc_i     (rsp_pc_q),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign bus.imem_addr = ADDR_WIDTH'(pc_to_word(64'(req_pc_q)));
  assign bus.out_pc    = skid_full ? skid_pc : rsp_pc_q;
  assign bus.out_instr = !out_valid ? '0 : (skid_full ? skid_instr : bus.imem_rdata);
`else
  assign slot_blocked = 1'b0;
  assign out_valid    = rsp_valid_q;
  // A stalled response stays "in flight": the same word is read again.
  assign rsp_valid_d  = issue || (stall && !redirect);

  assign bus.imem_addr = stall ? ADDR_WIDTH'(pc_to_word(64'(rsp_pc_q)))
                               : ADDR_WIDTH'(pc_to_word(64'(req_pc_q)));
  assign bus.out_pc    = rsp_pc_q;
  assign bus.out_instr = out_valid ? bus.imem_rdata : '0;
`endif

  assign bus.out_valid = out_valid;
  assign state_dbg_o   = state_q;

  always_comb begin
    req_pc_d = req_pc_q;
    if (redirect) begin
      req_pc_d = bus.redirect_pc & ALIGN_MASK;
    end else if (issue) begin
      req_pc_d = req_pc_q + PC_STEP;  // wraps modulo 2^ADDR_WIDTH
    end
  end

  assign rsp_pc_d = issue ? req_pc_q : rsp_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q    <= RESET_PC & ALIGN_MASK;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      req_pc_q    <= req_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // With no issue at this edge, something is still owed to decode after it
  // exactly when the current offer is being refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!redirect && bus.run) state_q <= FETCH;
        end
        FETCH: begin
          if (!redirect && !bus.run) state_q <= stall ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (redirect || !stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = AW + DW;

  logic         clk = 1'b0;
  logic         rst;
  fetch_state_t state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;

  logic [W-1:0] exp_q[$];

  fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model: word i holds 0x11*(i+1) ----------------
  logic [DW-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DW'((i + 1) * 17);
  end
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[5:0]];

  function automatic logic [W-1:0] exp_word(input logic [AW-1:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    return {pc, DW'((int'(idx) + 1) * 17)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic          stall_prev = 1'b0;
  logic [AW-1:0] hold_pc;
  logic [DW-1:0] hold_instr;
  logic [W-1:0]  sb_exp;

  always @(negedge clk) begin
    if (stall_prev) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== hold_pc || bus.out_instr !== hold_instr) begin
        miscompares++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 bus.out_valid, bus.out_pc, bus.out_instr, hold_pc, hold_instr);
      end
    end
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      accepted++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL accept_unexpected: pc=%h instr=%h, required no acceptance",
                 bus.out_pc, bus.out_instr);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({bus.out_pc, bus.out_instr} !== sb_exp) begin
          miscompares++;
          $display("FAIL accept_data: pc=%h instr=%h, required pc=%h instr=%h",
                   bus.out_pc, bus.out_instr, sb_exp[W-1:DW], sb_exp[DW-1:0]);
        end
      end
    end
    stall_prev = !rst && !bus.redirect_valid && bus.out_valid === 1'b1 && bus.out_ready === 1'b0;
    hold_pc    = bus.out_pc;
    hold_instr = bus.out_instr;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    bus.run            = r;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.out_instr !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b pc=%h instr=%h, required 0 0 0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    vectors++;
    if (bus.imem_addr !== 32'h0 || state_dbg !== IDLE) begin
      miscompares++;
      $display("FAIL reset_addr_state: addr=%h state=%0d, required addr=0 state=IDLE",
               bus.imem_addr, state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int tab[5] = '{-1, 0, 4, 8, -1};
    do_reset();
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'h4));
    exp_q.push_back(exp_word(32'h8));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(i < 3, 1'b1, 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (tab[i] < 0) begin
        if (bus.out_valid !== 1'b0 || bus.out_instr !== '0) begin
          miscompares++;
          $display("FAIL stream_idle c%0d: valid=%b instr=%h, required 0 0", i, bus.out_valid, bus.out_instr);
        end
      end else if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(AW'(tab[i]))) begin
        miscompares++;
        $display("FAIL stream_out c%0d: valid=%b pc=%h instr=%h, required pc=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, tab[i]);
      end
    end
    vectors++;
    if (state_dbg !== IDLE || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_end: state=%0d left=%0d, required IDLE 0", state_dbg, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int tab[9] = '{-1, 0, 4, 4, 4, 4, 8, 12, -1};
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_word(AW'(k * 4)));
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(i <= 6, (i < 2) || (i >= 5), 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (tab[i] < 0) begin
        if (bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_idle c%0d: valid=%b, required 0", i, bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(AW'(tab[i]))) begin
        miscompares++;
        $display("FAIL stall_out c%0d: valid=%b pc=%h instr=%h, required pc=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, tab[i]);
      end
`ifndef FETCH_SKID_EN
      if (i >= 2 && i <= 4) begin
        vectors++;
        if (bus.imem_addr !== 32'h1) begin
          miscompares++;
          $display("FAIL stall_reread c%0d: addr=%h, required 1", i, bus.imem_addr);
        end
      end
`endif
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_left: %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect(input logic [AW-1:0] rpc, input logic ready_at);
    int tab[8] = '{-1, 0, 4, 8, -1, 64, 68, -1};
    do_reset();
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'h4));
    if (ready_at) exp_q.push_back(exp_word(32'h8));
    exp_q.push_back(exp_word(32'h40));
    exp_q.push_back(exp_word(32'h44));
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 3) drive(1'b1, ready_at, 1'b1, rpc);
      else        drive(i <= 5, 1'b1, 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (tab[i] < 0) begin
        if (bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL redir_bubble c%0d: valid=%b, required 0", i, bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(AW'(tab[i]))) begin
        miscompares++;
        $display("FAIL redir_out c%0d: valid=%b pc=%h instr=%h, required pc=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, tab[i]);
      end
      if (i == 4) begin
        vectors++;
        if (bus.imem_addr !== 32'h10) begin
          miscompares++;
          $display("FAIL redir_addr: addr=%h, required 10", bus.imem_addr);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL redir_left: %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_run_drop();
    int tab[8] = '{-1, 0, 4, 8, 12, 12, 12, -1};
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_word(AW'(k * 4)));
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(i <= 3, !(i == 4 || i == 5), 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (tab[i] < 0) begin
        if (bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_idle c%0d: valid=%b, required 0", i, bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(AW'(tab[i]))) begin
        miscompares++;
        $display("FAIL drop_out c%0d: valid=%b pc=%h instr=%h, required pc=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, tab[i]);
      end
      if (i == 5) begin
        vectors++;
        if (state_dbg !== DRAIN) begin
          miscompares++;
          $display("FAIL drop_drain: state=%0d, required DRAIN", state_dbg);
        end
      end
      if (i == 7) begin
        vectors++;
        if (state_dbg !== IDLE || exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL drop_end: state=%0d left=%0d, required IDLE 0", state_dbg, exp_q.size());
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    exp_q.push_back(exp_word(32'hFFFF_FFFC));
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      case (i)
        0: drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        1, 2: drive(1'b1, 1'b1, 1'b0, '0);
        3: drive(1'b1, 1'b0, 1'b0, '0);
        4: begin drive(1'b1, 1'b0, 1'b0, '0); rst = 1'b1; end
        default: begin drive(1'b0, 1'b0, 1'b0, '0); rst = 1'b0; end
      endcase
      @(negedge clk);
      vectors++;
      case (i)
        1: if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h3FFF_FFFF) begin
             miscompares++;
             $display("FAIL wrap_issue: valid=%b addr=%h, required 0 3fffffff", bus.out_valid, bus.imem_addr);
           end
        2: if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(32'hFFFF_FFFC)) begin
             miscompares++;
             $display("FAIL wrap_top: valid=%b pc=%h instr=%h, required pc=fffffffc",
                      bus.out_valid, bus.out_pc, bus.out_instr);
           end
        3, 4: if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== exp_word(32'h0)) begin
             miscompares++;
             $display("FAIL wrap_zero c%0d: valid=%b pc=%h instr=%h, required pc=0",
                      i, bus.out_valid, bus.out_pc, bus.out_instr);
           end
        5: if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.out_instr !== '0 ||
               bus.imem_addr !== '0 || state_dbg !== IDLE) begin
             miscompares++;
             $display("FAIL midreset: valid=%b pc=%h instr=%h addr=%h state=%0d, required all 0 IDLE",
                      bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr, state_dbg);
           end
        default: if (bus.out_valid !== 1'b0) begin
             miscompares++;
             $display("FAIL wrap_redir_idle: valid=%b, required 0", bus.out_valid);
           end
      endcase
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_left: %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    int  acc0;
    bit  drained;
    do_reset();
    acc0 = accepted;
    for (int k = 0; k < 60; k++) exp_q.push_back(exp_word(AW'(k * 4)));
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      drive(1'b1, $urandom_range(0, 3) != 0, 1'b0, '0);
    end
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (state_dbg === IDLE && bus.out_valid === 1'b0) drained = 1'b1;
    end
    vectors++;
    if (!drained) begin
      miscompares++;
      $display("FAIL rand_drain: state=%0d valid=%b after 10 cycles, required IDLE 0", state_dbg, bus.out_valid);
    end
    // Every issued word was delivered, so the next word address equals
    // the number of acceptances.
    vectors++;
    if (bus.imem_addr !== AW'(accepted - acc0)) begin
      miscompares++;
      $display("FAIL rand_count: addr=%h, required %h", bus.imem_addr, accepted - acc0);
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h40, 1'b0);
    test_redirect(32'h43, 1'b1);
    test_run_drop();
    test_wrap_reset();
    test_random_ready();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
